// File: rtl/mem_arbiter_np.sv
// N-port in-order arbiter sharing one single-port RAM among request/grant/rvalid hosts.
// Fixed-priority or round-robin grant, tag pipeline for responses, window errors, sticky RAM checker.
module mem_arbiter_np #(
  parameter int          NUM_PORTS   = 2,
  parameter int          ARB_MODE    = 0,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] MEM_START   = 32'h0000_0000,
  parameter int          MEM_SIZE    = 65536
) (
  input  logic                      clk_sys,
  input  logic                      rst_sys_n,
  input  logic [NUM_PORTS-1:0]      req_i,
  input  logic [NUM_PORTS-1:0]      we_i,
  input  logic [4*NUM_PORTS-1:0]    be_i,
  input  logic [32*NUM_PORTS-1:0]   addr_i,
  input  logic [32*NUM_PORTS-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]      gnt_o,
  output logic [NUM_PORTS-1:0]      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [31:0]               mem_rdata_i,
  output logic                      proto_err_o
);

  localparam int          IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] WIN_MASK = ~(32'(MEM_SIZE) - 32'd1);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] port;
    logic             err;
  } tag_t;

  logic [3:0]       be_arr    [NUM_PORTS];
  logic [31:0]      addr_arr  [NUM_PORTS];
  logic [31:0]      wdata_arr [NUM_PORTS];

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] search_base;
  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             in_win;

  tag_t             tags [MEM_LATENCY];
  tag_t             tag_in;
  tag_t             tag_exit;
  logic             proto_err_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign be_arr[p]    = be_i[4*p +: 4];
    assign addr_arr[p]  = addr_i[32*p +: 32];
    assign wdata_arr[p] = wdata_i[32*p +: 32];
  end

  assign search_base = (ARB_MODE == 1) ? rr_ptr : '0;

  // Priority search starting at search_base, wrapping modulo NUM_PORTS; grants are held off while in reset.
  always_comb begin : arbitrate
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_sum = {1'b0, search_base} + (IDX_W+1)'(i);
      if (cand_sum >= (IDX_W+1)'(NUM_PORTS)) begin
        cand_sum = cand_sum - (IDX_W+1)'(NUM_PORTS);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!win_found && req_i[cand] && rst_sys_n) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign in_win = ((addr_arr[win_idx] & WIN_MASK) == MEM_START);

  // Out-of-window winners are granted but never reach the RAM.
  always_comb begin : drive_mem
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (win_found) begin
      gnt_o[win_idx] = 1'b1;
      if (in_win) begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_i[win_idx];
        mem_be_o    = be_arr[win_idx];
        mem_addr_o  = addr_arr[win_idx];
        mem_wdata_o = wdata_arr[win_idx];
      end
    end
  end

  always_comb begin : build_tag
    tag_in       = '0;
    tag_in.valid = win_found;
    tag_in.port  = win_idx;
    tag_in.err   = win_found && !in_win;
  end

  // One stage per RAM latency cycle keeps responses in grant order.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin : tag_pipe
    if (!rst_sys_n) begin
      for (int s = 0; s < MEM_LATENCY; s++) begin
        tags[s] <= '0;
      end
    end else begin
      tags[0] <= tag_in;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        tags[s] <= tags[s-1];
      end
    end
  end

  assign tag_exit = tags[MEM_LATENCY-1];

  always_comb begin : respond
    rvalid_o = '0;
    err_o    = 1'b0;
    rdata_o  = '0;
    if (tag_exit.valid) begin
      rvalid_o[tag_exit.port] = 1'b1;
      err_o                   = tag_exit.err;
      if (!tag_exit.err) begin
        rdata_o = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin : rr_update
    if (!rst_sys_n) begin
      rr_ptr <= '0;
    end else if (win_found) begin
      rr_ptr <= (win_idx == IDX_W'(NUM_PORTS-1)) ? '0 : win_idx + 1'b1;
    end
  end

  // RAM must answer exactly for tags that actually issued a request.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin : proto_check
    if (!rst_sys_n) begin
      proto_err_q <= 1'b0;
    end else if (mem_rvalid_i != (tag_exit.valid && !tag_exit.err)) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter_np.sv
// Directed bench for mem_arbiter_np: three instances (2-port fixed, 3-port fixed, 3-port round-robin latency 3).
// Each instance sees a small behavioural RAM with the matching read latency.
module tb_mem_arbiter_np;

  logic clk_sys = 1'b0;
  logic rst_sys_n;
  always #5 clk_sys = ~clk_sys;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
  logic [7:0]  a_be;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic        a_err, a_mreq, a_mwe, a_mrvalid, a_perr;
  logic [3:0]  a_mbe;

  logic [2:0]  b_req, b_we, b_gnt, b_rvalid;
  logic [11:0] b_be;
  logic [95:0] b_addr, b_wdata;
  logic [31:0] b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic        b_err, b_mreq, b_mwe, b_mrvalid, b_perr;
  logic [3:0]  b_mbe;

  logic [2:0]  c_req, c_we, c_gnt, c_rvalid;
  logic [11:0] c_be;
  logic [95:0] c_addr, c_wdata;
  logic [31:0] c_rdata, c_maddr, c_mwdata, c_mrdata;
  logic        c_err, c_mreq, c_mwe, c_mrvalid, c_perr, c_stray;
  logic [3:0]  c_mbe;

  mem_arbiter_np #(.NUM_PORTS(2), .ARB_MODE(0), .MEM_LATENCY(1),
                   .MEM_START(32'h0), .MEM_SIZE(65536)) dut_a (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .req_i(a_req), .we_i(a_we), .be_i(a_be), .addr_i(a_addr), .wdata_i(a_wdata),
    .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err),
    .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_be_o(a_mbe),
    .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata),
    .mem_rvalid_i(a_mrvalid), .mem_rdata_i(a_mrdata), .proto_err_o(a_perr));

  mem_arbiter_np #(.NUM_PORTS(3), .ARB_MODE(0), .MEM_LATENCY(1),
                   .MEM_START(32'h0), .MEM_SIZE(65536)) dut_b (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .req_i(b_req), .we_i(b_we), .be_i(b_be), .addr_i(b_addr), .wdata_i(b_wdata),
    .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err),
    .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_be_o(b_mbe),
    .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata),
    .mem_rvalid_i(b_mrvalid), .mem_rdata_i(b_mrdata), .proto_err_o(b_perr));

  mem_arbiter_np #(.NUM_PORTS(3), .ARB_MODE(1), .MEM_LATENCY(3),
                   .MEM_START(32'h0), .MEM_SIZE(65536)) dut_c (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .req_i(c_req), .we_i(c_we), .be_i(c_be), .addr_i(c_addr), .wdata_i(c_wdata),
    .gnt_o(c_gnt), .rvalid_o(c_rvalid), .rdata_o(c_rdata), .err_o(c_err),
    .mem_req_o(c_mreq), .mem_we_o(c_mwe), .mem_be_o(c_mbe),
    .mem_addr_o(c_maddr), .mem_wdata_o(c_mwdata),
    .mem_rvalid_i(c_mrvalid), .mem_rdata_i(c_mrdata), .proto_err_o(c_perr));

  // Behavioural RAMs: byte-enabled writes, read data delayed by the instance latency.
  logic [31:0] a_mem [0:255];
  logic [31:0] b_mem [0:255];
  logic [31:0] c_mem [0:255];
  logic        a_pv, b_pv;
  logic [31:0] a_pd, b_pd;
  logic [2:0]  c_pv;
  logic [31:0] c_pd [3];

  always @(posedge clk_sys) begin
    for (int k = 0; k < 4; k++) begin
      if (a_mreq && a_mwe && a_mbe[k]) a_mem[a_maddr[9:2]][8*k +: 8] <= a_mwdata[8*k +: 8];
      if (b_mreq && b_mwe && b_mbe[k]) b_mem[b_maddr[9:2]][8*k +: 8] <= b_mwdata[8*k +: 8];
      if (c_mreq && c_mwe && c_mbe[k]) c_mem[c_maddr[9:2]][8*k +: 8] <= c_mwdata[8*k +: 8];
    end
  end

  always @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      a_pv <= 1'b0; a_pd <= '0;
      b_pv <= 1'b0; b_pd <= '0;
      c_pv <= '0;
      for (int k = 0; k < 3; k++) c_pd[k] <= '0;
    end else begin
      a_pv <= a_mreq; a_pd <= a_mem[a_maddr[9:2]];
      b_pv <= b_mreq; b_pd <= b_mem[b_maddr[9:2]];
      c_pv <= {c_pv[1:0], c_mreq};
      c_pd[0] <= c_mem[c_maddr[9:2]];
      c_pd[1] <= c_pd[0];
      c_pd[2] <= c_pd[1];
    end
  end

  assign a_mrvalid = a_pv;
  assign a_mrdata  = a_pd;
  assign b_mrvalid = b_pv;
  assign b_mrdata  = b_pd;
  assign c_mrvalid = c_pv[2] | c_stray;
  assign c_mrdata  = c_pd[2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_sys);
    #1;
  endtask

  // Drives one port of the round-robin instance.
  task automatic applyStimulus(input int p, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    c_req[p]          = req;
    c_we[p]           = we;
    c_be[4*p +: 4]    = 4'hF;
    c_addr[32*p +: 32]  = addr;
    c_wdata[32*p +: 32] = wdata;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [2:0] rr_exp [6];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    a_req = '0; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_be = '0; b_addr = '0; b_wdata = '0;
    c_req = '0; c_we = '0; c_be = '0; c_addr = '0; c_wdata = '0;
    c_stray = 1'b0;
    rst_sys_n = 1'b1;
    #2 rst_sys_n = 1'b0;

    repeat (2) @(posedge clk_sys);
    #3;
    c_req = 3'b111;
    #1;
    checkOutput("rst_a_gnt",    32'(a_gnt),    32'h0);
    checkOutput("rst_a_rvalid", 32'(a_rvalid), 32'h0);
    checkOutput("rst_a_rdata",  a_rdata,       32'h0);
    checkOutput("rst_a_err",    32'(a_err),    32'h0);
    checkOutput("rst_a_mreq",   32'(a_mreq),   32'h0);
    checkOutput("rst_a_perr",   32'(a_perr),   32'h0);
    checkOutput("rst_c_gnt_gated", 32'(c_gnt), 32'h0);
    checkOutput("rst_c_mreq",   32'(c_mreq),   32'h0);
    c_req = '0;
    nextCycle();
    rst_sys_n = 1'b1;

    // Single write then read on the 2-port instance.
    a_req = 2'b01; a_we = 2'b01; a_be = 8'h0F;
    a_addr[31:0] = 32'h100; a_wdata[31:0] = 32'hDEADBEEF;
    #2;
    checkOutput("a_wr_gnt",   32'(a_gnt),  32'h1);
    checkOutput("a_wr_mreq",  32'(a_mreq), 32'h1);
    checkOutput("a_wr_mwe",   32'(a_mwe),  32'h1);
    checkOutput("a_wr_mbe",   32'(a_mbe),  32'hF);
    checkOutput("a_wr_maddr", a_maddr,     32'h100);
    checkOutput("a_wr_mwdata", a_mwdata,   32'hDEADBEEF);
    nextCycle();
    a_we = 2'b00;
    #2;
    checkOutput("a_rd_gnt",     32'(a_gnt),    32'h1);
    checkOutput("a_rd_mwe",     32'(a_mwe),    32'h0);
    checkOutput("a_wr_rvalid",  32'(a_rvalid), 32'h1);
    checkOutput("a_wr_err",     32'(a_err),    32'h0);
    nextCycle();
    a_req = 2'b00;
    #2;
    checkOutput("a_rd_rvalid", 32'(a_rvalid), 32'h1);
    checkOutput("a_rd_rdata",  a_rdata,       32'hDEADBEEF);
    checkOutput("a_rd_err",    32'(a_err),    32'h0);
    checkOutput("a_idle_mreq", 32'(a_mreq),   32'h0);
    checkOutput("a_idle_gnt",  32'(a_gnt),    32'h0);

    // Contention on the fixed-priority 2-port instance.
    nextCycle();
    a_req = 2'b11; a_addr[63:32] = 32'h104;
    #2;
    checkOutput("a_both_gnt",   32'(a_gnt), 32'h1);
    checkOutput("a_both_maddr", a_maddr,    32'h100);
    nextCycle();
    a_req = 2'b10;
    #2;
    checkOutput("a_p1_gnt",    32'(a_gnt),    32'h2);
    checkOutput("a_p1_maddr",  a_maddr,       32'h104);
    checkOutput("a_p0_rvalid", 32'(a_rvalid), 32'h1);

    // Out-of-window read on port 1.
    nextCycle();
    a_addr[63:32] = 32'h0001_0000;
    #2;
    checkOutput("a_oow_gnt",    32'(a_gnt),    32'h2);
    checkOutput("a_oow_mreq",   32'(a_mreq),   32'h0);
    checkOutput("a_oow_maddr",  a_maddr,       32'h0);
    checkOutput("a_p1_rvalid",  32'(a_rvalid), 32'h2);
    checkOutput("a_p1_err",     32'(a_err),    32'h0);
    nextCycle();
    a_req = 2'b00;
    #2;
    checkOutput("a_oow_rvalid", 32'(a_rvalid), 32'h2);
    checkOutput("a_oow_err",    32'(a_err),    32'h1);
    checkOutput("a_oow_rdata",  a_rdata,       32'h0);
    nextCycle();
    #2;
    checkOutput("a_oow_perr",   32'(a_perr),   32'h0);
    checkOutput("a_end_rvalid", 32'(a_rvalid), 32'h0);

    // Fixed priority with three continuous requesters.
    nextCycle();
    b_be = 12'hFFF;
    b_addr = {32'h8, 32'h4, 32'h0};
    for (int k = 0; k < 4; k++) begin
      b_req = 3'b111;
      #2;
      checkOutput($sformatf("b_fix_gnt%0d", k), 32'(b_gnt), 32'h1);
      if (k > 0) checkOutput($sformatf("b_fix_rv%0d", k), 32'(b_rvalid), 32'h1);
      nextCycle();
    end
    b_req = 3'b110;
    #2;
    checkOutput("b_p1_gnt", 32'(b_gnt),    32'h2);
    checkOutput("b_p1_rv",  32'(b_rvalid), 32'h1);
    nextCycle();
    b_req = 3'b100;
    #2;
    checkOutput("b_p2_gnt", 32'(b_gnt),    32'h4);
    checkOutput("b_p2_rv",  32'(b_rvalid), 32'h2);
    nextCycle();
    b_req = 3'b000;
    #2;
    checkOutput("b_end_gnt",  32'(b_gnt),    32'h0);
    checkOutput("b_end_rv",   32'(b_rvalid), 32'h4);
    checkOutput("b_end_err",  32'(b_err),    32'h0);
    checkOutput("b_end_perr", 32'(b_perr),   32'h0);

    // Round-robin over three ports with latency 3.
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h8, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #2;
      checkOutput($sformatf("c_rr_gnt%0d", k), 32'(c_gnt), 32'(rr_exp[k]));
      if (k >= 3) checkOutput($sformatf("c_rr_rv%0d", k), 32'(c_rvalid), 32'(rr_exp[k-3]));
      nextCycle();
    end
    c_req = 3'b000;
    for (int k = 0; k < 3; k++) begin
      #2;
      checkOutput($sformatf("c_rr_drain%0d", k), 32'(c_rvalid), 32'(rr_exp[3+k]));
      checkOutput($sformatf("c_rr_idle%0d", k),  32'(c_gnt),    32'h0);
      nextCycle();
    end

    // In-order responses: write then read of the same word.
    applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h55);
    #2;
    checkOutput("c_io_gnt0", 32'(c_gnt),    32'h1);
    checkOutput("c_io_rv0",  32'(c_rvalid), 32'h0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
    #2;
    checkOutput("c_io_gnt1", 32'(c_gnt), 32'h2);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("c_io_rv_t2", 32'(c_rvalid), 32'h0);
    nextCycle();
    #2;
    checkOutput("c_io_rv_t3",  32'(c_rvalid), 32'h1);
    checkOutput("c_io_err_t3", 32'(c_err),    32'h0);
    nextCycle();
    #2;
    checkOutput("c_io_rv_t4",    32'(c_rvalid), 32'h2);
    checkOutput("c_io_rdata_t4", c_rdata,       32'h55);
    checkOutput("c_io_err_t4",   32'(c_err),    32'h0);
    nextCycle();
    #2;
    checkOutput("c_io_rv_t5", 32'(c_rvalid), 32'h0);
    checkOutput("c_io_perr",  32'(c_perr),   32'h0);

    // Reset mid-flight: two grants outstanding, pointer left at 1.
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
    #2;
    checkOutput("c_mf_gnt0", 32'(c_gnt), 32'h2);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h24, 32'h0);
    #2;
    checkOutput("c_mf_gnt1", 32'(c_gnt), 32'h1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_sys_n = 1'b0;
    #2;
    checkOutput("c_mf_rv_in_rst", 32'(c_rvalid), 32'h0);
    nextCycle();
    rst_sys_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      checkOutput($sformatf("c_mf_rv_after%0d", k), 32'(c_rvalid), 32'h0);
      nextCycle();
    end
    #2;
    checkOutput("c_mf_perr_clean", 32'(c_perr), 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    checkOutput("c_mf_ptr_reset_gnt", 32'(c_gnt), 32'h1);
    nextCycle();
    c_req = 3'b000;
    nextCycle();
    nextCycle();
    #2;
    checkOutput("c_mf_post_rv", 32'(c_rvalid), 32'h1);
    nextCycle();
    #2;
    checkOutput("c_stray_pre_perr", 32'(c_perr), 32'h0);
    c_stray = 1'b1;
    nextCycle();
    c_stray = 1'b0;
    #2;
    checkOutput("c_stray_perr", 32'(c_perr), 32'h1);
    nextCycle();
    #2;
    checkOutput("c_stray_sticky", 32'(c_perr), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_np.md
# mem_arbiter_np

N-port, in-order arbiter that shares one single-port RAM among several Ibex-style request/grant/rvalid hosts: instruction fetch, LSU, and bench DMA/BFM agents. It generalises the fixed two-way instr/data mux that today sits between `ibex_core` and `ram_1p`. It adds a parametrised port count, fixed-priority or round-robin arbitration, a configurable RAM read latency, out-of-window error responses, and a sticky RAM-protocol checker. It sits in the bench top between the core/BFM request ports and `ram_1p`.

## Interface
- NUM_PORTS, 2: number of host ports (2..8).
- ARB_MODE, 0: 0 = fixed priority (port 0 highest); 1 = round-robin.
- MEM_LATENCY, 1: RAM cycles from accepted mem_req_o to mem_rvalid_i/mem_rdata_i (1..4).
- MEM_START, 32'h0000_0000: base of RAM window.
- MEM_SIZE, 65536: window size in bytes (power of two).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- rst_sys_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_PORTS  per-port request.
- we_i  in  NUM_PORTS  per-port write enable.
- be_i  in  4*NUM_PORTS  byte enables; port p at [4p+3:4p].
- addr_i  in  32*NUM_PORTS  byte address; port p at [32p+31:32p].
- wdata_i  in  32*NUM_PORTS  write data.
- gnt_o  out  NUM_PORTS  grant, one-hot or zero.
- rvalid_o  out  NUM_PORTS  response valid, one-hot or zero.
- rdata_o  out  32  shared response data; valid only for the port with rvalid_o set.
- err_o  out  1  response error, qualified by any rvalid_o bit.
- mem_req_o, mem_we_o  out  1  RAM request / write.
- mem_be_o  out  4  RAM byte enables.
- mem_addr_o, mem_wdata_o  out  32  RAM address / write data.
- mem_rvalid_i  in  1  RAM response valid.
- mem_rdata_i  in  32  RAM read data.
- proto_err_o  out  1  sticky: RAM rvalid disagreed with expected response.

## Operation
- Arbitration is combinational among ports with req_i=1. At most one winner per cycle, and the winner's gnt_o is asserted in that same cycle.
- Fixed mode: the lowest-index requester wins, and starvation of higher indices is allowed.
- Round-robin mode: a pointer rr_ptr holds the highest-priority index. Search starts at rr_ptr and wraps modulo NUM_PORTS. After a grant to port p, rr_ptr <= (p+1) mod NUM_PORTS. rr_ptr is unchanged when nothing is granted.
- Window check: in_win = (addr & ~(MEM_SIZE-1)) == MEM_START.
- Granted and in_win: drive mem_req_o=1 with the winner's we/be/addr/wdata.
- Granted and not in_win: mem_req_o=0, and the transaction still completes with an error response.
- No winner: all mem_* outputs are 0.
- Every granted transaction, read or write, produces exactly one response.
- Tag pipeline: a MEM_LATENCY-deep shift register of {valid, port index, err}. A grant loads stage 0, and the response is issued when the tag exits the last stage.
- At tag exit: rvalid_o[port]=1 and err_o=err. rdata_o = mem_rdata_i if err=0, else 0.
- Responses are strictly in grant order; no reordering.
- Checker: proto_err_o sets when mem_rvalid_i != (exiting tag valid && !err). It stays set until reset.

## Timing
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, all mem_* outputs 0, proto_err_o=0, tag pipeline cleared, rr_ptr=0.
- Grant latency is 0 cycles: gnt_o asserts in the same cycle as req_i if the port wins.
- Throughput is one grant per cycle. Back-to-back grants are allowed, since the pipeline holds MEM_LATENCY in-flight tags.
- Response latency: granted in cycle t gives rvalid_o in cycle t+MEM_LATENCY, for both RAM and error paths.
- A host may drop req_i after gnt_o. Inputs are sampled only in the grant cycle.
- Simultaneous response exit and new grant in the same cycle: both proceed independently.
- Reset asserted mid-operation: all in-flight tags are discarded, no rvalid_o is emitted for them after release, and rr_ptr returns to 0.
- Port indices ≥ NUM_PORTS never appear. rr_ptr wrap from NUM_PORTS-1 goes to 0.

## Test plan
- Single read: NUM_PORTS=2, MEM_LATENCY=1, port0 reads 0x100 holding 0xDEADBEEF. Expect gnt_o=01 and mem_req_o=1 in cycle t; rvalid_o=01, rdata_o=0xDEADBEEF, err_o=0 at t+1.
- Fixed priority: NUM_PORTS=3, ARB_MODE=0, all three requesting continuously for 4 cycles. Expect gnt_o=001 every cycle. Expect port 1 granted only once port 0 drops req.
- Round-robin: NUM_PORTS=3, ARB_MODE=1, all requesting for 6 cycles. Expect grant order 0,1,2,0,1,2.
- Out of window: port1 reads 0x0001_0000 with MEM_SIZE=64 kB. Expect gnt_o=10, mem_req_o=0; rvalid_o=10, err_o=1, rdata_o=0 after MEM_LATENCY; proto_err_o stays 0.
- In-order, latency 3: port0 writes 0x20=0x55, then port1 reads 0x20 on the next cycle. Expect rvalid_o to port0 at t+3 and port1 at t+4 with rdata_o=0x55.
- Reset mid-flight: MEM_LATENCY=3, two grants issued, then rst_sys_n pulsed low for 1 cycle. Expect no rvalid_o after release, rr_ptr=0, and a forced stray mem_rvalid_i to set proto_err_o=1.
